operand_fetch: RTL and testbench



---
 rtl/operand_fetch_pkg.sv | 55 +++++
 rtl/operand_fetch_reg_file.sv | 39 +++
 rtl/operand_fetch.sv | 101 ++++++++++
 tb/tb_operand_fetch.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/operand_fetch_pkg.sv
// Shared definitions for the decode / operand-fetch / writeback stages:
// datapath width, register count, opcode encodings and instruction field helpers.
package operand_fetch_pkg;

   localparam int unsigned XLEN   = 32;
   localparam int unsigned NREG   = 32;
   localparam int unsigned REG_AW = 5;

   localparam int unsigned OPC_LSB = 0;
   localparam int unsigned OPC_W   = 7;
   localparam int unsigned RD_LSB  = 7;
   localparam int unsigned RS1_LSB = 15;
   localparam int unsigned RS2_LSB = 20;

   typedef enum logic [OPC_W-1:0] {
      OP_LUI    = 7'b0110111,
      OP_AUIPC  = 7'b0010111,
      OP_JAL    = 7'b1101111,
      OP_JALR   = 7'b1100111,
      OP_LOAD   = 7'b0000011,
      OP_STORE  = 7'b0100011,
      OP_BRANCH = 7'b1100011,
      OP_REG    = 7'b0110011,
      OP_IMM    = 7'b0010011
   } opcode_e;

   function automatic logic [REG_AW-1:0] rs1_of(input logic [31:0] ir);
      return ir[RS1_LSB +: REG_AW];
   endfunction

   function automatic logic [REG_AW-1:0] rs2_of(input logic [31:0] ir);
      return ir[RS2_LSB +: REG_AW];
   endfunction

   function automatic logic [REG_AW-1:0] rd_of(input logic [31:0] ir);
      return ir[RD_LSB +: REG_AW];
   endfunction

   function automatic logic [OPC_W-1:0] opcode_of(input logic [31:0] ir);
      return ir[OPC_LSB +: OPC_W];
   endfunction

   function automatic logic uses_rs1(input logic [OPC_W-1:0] op);
      return !(op == OP_LUI || op == OP_AUIPC || op == OP_JAL);
   endfunction

   function automatic logic uses_rs2(input logic [OPC_W-1:0] op);
      return (op == OP_REG || op == OP_STORE || op == OP_BRANCH);
   endfunction

   function automatic logic writes_rd(input logic [OPC_W-1:0] op, input logic [REG_AW-1:0] rd);
      return !(op == OP_STORE || op == OP_BRANCH) && (rd != '0);
   endfunction

endpackage

// File: rtl/operand_fetch_reg_file.sv
// reg_file: NREG x WIDTH register file, one write port, two combinational
// read ports, x0 hardwired to zero. Define REG_BYPASS_EN for same-cycle
// write-through from the write port to the read ports.
module reg_file #(
   parameter int unsigned WIDTH = operand_fetch_pkg::XLEN,
   parameter int unsigned DEPTH = operand_fetch_pkg::NREG
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic [operand_fetch_pkg::REG_AW-1:0] wr_addr,
   input  logic [WIDTH-1:0]                     wr_data,
   input  logic [operand_fetch_pkg::REG_AW-1:0] rd_addr1,
   input  logic [operand_fetch_pkg::REG_AW-1:0] rd_addr2,
   output logic [WIDTH-1:0]                     rd_data1,
   output logic [WIDTH-1:0]                     rd_data2
);

   logic [WIDTH-1:0] regs [DEPTH];

   // Commit the writeback port; address 0 is a no-write
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < DEPTH; i++) regs[i] <= '0;
      end else if (wr_addr != '0) begin
         regs[wr_addr] <= wr_data;
      end
   end

   // Combinational reads, x0 forced to zero, optional write-through
   always_comb begin
      rd_data1 = (rd_addr1 == '0) ? '0 : regs[rd_addr1];
      rd_data2 = (rd_addr2 == '0) ? '0 : regs[rd_addr2];
`ifdef REG_BYPASS_EN
      if (rd_addr1 != '0 && rd_addr1 == wr_addr) rd_data1 = wr_data;
      if (rd_addr2 != '0 && rd_addr2 == wr_addr) rd_data2 = wr_data;
`endif
   end

endmodule

// File: rtl/operand_fetch.sv
// operand_fetch: owns the register file, reads rs1/rs2 for the decoded
// instruction, tracks pending destinations in a busy scoreboard, stalls on
// RAW hazards and hands a registered operand bundle to execute.
// Define REG_BYPASS_EN to let a same-cycle writeback forward data and clear
// the hazard; otherwise a dependent instruction waits for the commit.
module operand_fetch #(
   parameter int unsigned XLEN = operand_fetch_pkg::XLEN,
   parameter int unsigned NREG = operand_fetch_pkg::NREG
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic                                 in_valid,
   output logic                                 in_ready,
   input  logic [31:0]                          in_IR,
   input  logic [XLEN-1:0]                      in_PC,
   input  logic [XLEN-1:0]                      wb_data,
   input  logic [operand_fetch_pkg::REG_AW-1:0] wb_address,
   output logic                                 out_valid,
   input  logic                                 out_ready,
   output logic [31:0]                          out_IR,
   output logic [XLEN-1:0]                      out_PC,
   output logic [XLEN-1:0]                      out_A,
   output logic [XLEN-1:0]                      out_B
);

   import operand_fetch_pkg::*;

   logic [REG_AW-1:0] rs1, rs2, rd;
   logic [OPC_W-1:0]  opcode;
   logic              use1, use2, wr_rd;
   logic              clr1, clr2, hazard, issue;
   logic [XLEN-1:0]   rdata1, rdata2;
   logic [NREG-1:0]   busy;

   assign rs1    = rs1_of(in_IR);
   assign rs2    = rs2_of(in_IR);
   assign rd     = rd_of(in_IR);
   assign opcode = opcode_of(in_IR);
   assign use1   = uses_rs1(opcode);
   assign use2   = uses_rs2(opcode);
   assign wr_rd  = writes_rd(opcode, rd);

   reg_file #(
      .WIDTH (XLEN),
      .DEPTH (NREG)
   ) u_reg_file (
      .clk      (clk),
      .rst      (rst),
      .wr_addr  (wb_address),
      .wr_data  (wb_data),
      .rd_addr1 (rs1),
      .rd_addr2 (rs2),
      .rd_data1 (rdata1),
      .rd_data2 (rdata2)
   );

   // Hazard detection and the decode-side handshake
   always_comb begin
`ifdef REG_BYPASS_EN
      clr1 = (wb_address == rs1);
      clr2 = (wb_address == rs2);
`else
      clr1 = 1'b0;
      clr2 = 1'b0;
`endif
      hazard   = (use1 && busy[rs1] && !clr1) || (use2 && busy[rs2] && !clr2);
      in_ready = (!out_valid || out_ready) && !hazard && !rst;
      issue    = in_valid && in_ready;
   end

   // Operand bundle register towards execute; holds while stalled downstream
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_IR    <= '0;
         out_PC    <= '0;
         out_A     <= '0;
         out_B     <= '0;
      end else if (issue) begin
         out_valid <= 1'b1;
         out_IR    <= in_IR;
         out_PC    <= in_PC;
         out_A     <= rdata1;
         out_B     <= rdata2;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

   // Busy scoreboard: writeback clears, issue sets (later assignment wins)
   always_ff @(posedge clk) begin
      if (rst) begin
         busy <= '0;
      end else begin
         if (wb_address != '0) busy[wb_address] <= 1'b0;
         if (issue && wr_rd)   busy[rd]         <= 1'b1;
         busy[0] <= 1'b0;
      end
   end

endmodule

// File: tb/tb_operand_fetch.sv
// Scoreboard bench for operand_fetch: the stimulus side pushes the expected
// bundle on every accept, a monitor pops and compares on each out handshake.
// Works with or without REG_BYPASS_EN defined.
module tb_operand_fetch;

   logic        clk = 1'b0;
   logic        rst, in_valid, in_ready, out_valid, out_ready;
   logic [31:0] in_IR, in_PC, wb_data, out_IR, out_PC, out_A, out_B;
   logic [4:0]  wb_address;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [31:0] ir;
      logic [31:0] pc;
      logic [31:0] a;
      logic [31:0] b;
   } bundle_t;

   bundle_t exp_q[$];
   bundle_t mon_e;

   always #5 clk = ~clk;

   operand_fetch dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_IR      (in_IR),
      .in_PC      (in_PC),
      .wb_data    (wb_data),
      .wb_address (wb_address),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_IR     (out_IR),
      .out_PC     (out_PC),
      .out_A      (out_A),
      .out_B      (out_B)
   );

   function automatic logic [31:0] r_type(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
      return {7'd0, rs2, rs1, 3'd0, rd, 7'b0110011};
   endfunction

   function automatic logic [31:0] i_type(input logic [4:0] rd, input logic [4:0] rs1, input logic [11:0] imm);
      return {imm, rs1, 3'd0, rd, 7'b0010011};
   endfunction

   function automatic logic [31:0] s_type(input logic [4:0] rs2, input logic [4:0] rs1, input logic [4:0] lo);
      return {7'd0, rs2, rs1, 3'b010, lo, 7'b0100011};
   endfunction

   function automatic logic [31:0] b_type(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] lo);
      return {7'd0, rs2, rs1, 3'd0, lo, 7'b1100011};
   endfunction

   function automatic logic [31:0] lui(input logic [4:0] rd, input logic [19:0] imm);
      return {imm, rd, 7'b0110111};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic push_exp(input logic [31:0] ir, input logic [31:0] pc,
                           input logic [31:0] a, input logic [31:0] b);
      bundle_t e;
      e.ir = ir; e.pc = pc; e.a = a; e.b = b;
      exp_q.push_back(e);
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Present an instruction until accepted (bounded), then check 1-cycle latency
   task automatic issue(input logic [31:0] ir, input logic [31:0] pc,
                        input logic [31:0] ea, input logic [31:0] eb,
                        input string name, output int stalls);
      bit done;
      done = 1'b0;
      stalls = 0;
      in_valid = 1'b1; in_IR = ir; in_PC = pc;
      while (!done) begin
         @(negedge clk);
         if (in_ready) begin
            done = 1'b1;
         end else begin
            stalls++;
            if (stalls > 20) begin
               checks++; errors++;
               $display("FAIL %s_accept: got no accept in %0d cycles, expected accept", name, stalls);
               in_valid = 1'b0;
               tick;
               return;
            end
            tick;
         end
      end
      push_exp(ir, pc, ea, eb);
      tick;
      in_valid = 1'b0;
      @(negedge clk);
      check({name, "_latency"}, {31'd0, out_valid}, 32'd1);
      tick;
   endtask

   // Instruction stalled on a busy register, released by writeback of that register
   task automatic raw_release(input logic [31:0] ir, input logic [31:0] pc,
                              input logic [4:0] wa, input logic [31:0] wd,
                              input logic [31:0] ea, input logic [31:0] eb, input string name);
      in_valid = 1'b1; in_IR = ir; in_PC = pc;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         check({name, "_stall"}, {31'd0, in_ready}, 32'd0);
         tick;
      end
      wb_address = wa; wb_data = wd;
      @(negedge clk);
`ifdef REG_BYPASS_EN
      check({name, "_bypass_accept"}, {31'd0, in_ready}, 32'd1);
      if (in_ready) push_exp(ir, pc, ea, eb);
      tick;
      in_valid = 1'b0; wb_address = '0;
`else
      check({name, "_wb_cycle_stall"}, {31'd0, in_ready}, 32'd0);
      tick;
      wb_address = '0;
      @(negedge clk);
      check({name, "_accept"}, {31'd0, in_ready}, 32'd1);
      if (in_ready) push_exp(ir, pc, ea, eb);
      tick;
      in_valid = 1'b0;
`endif
      @(negedge clk);
      tick;
   endtask

   // Monitor: compare every bundle execute accepts against the scoreboard
   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_bundle: got IR %h, expected none", out_IR);
         end else begin
            mon_e = exp_q.pop_front();
            check("out_IR", out_IR, mon_e.ir);
            check("out_PC", out_PC, mon_e.pc);
            check("out_A",  out_A,  mon_e.a);
            check("out_B",  out_B,  mon_e.b);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int s;
      logic [31:0] ir;
      rst = 1'b1; in_valid = 1'b1; in_IR = r_type(5'd1, 5'd0, 5'd0); in_PC = '0;
      wb_address = '0; wb_data = '0; out_ready = 1'b1;

      // Reset state
      tick; tick;
      @(negedge clk);
      check("rst_in_ready", {31'd0, in_ready},  32'd0);
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_out_IR", out_IR, 32'd0);
      check("rst_out_PC", out_PC, 32'd0);
      check("rst_out_A",  out_A,  32'd0);
      check("rst_out_B",  out_B,  32'd0);
      tick;
      rst = 1'b0; in_valid = 1'b0;

      // Write x5, then read it
      wb_address = 5'd5; wb_data = 32'hDEADBEEF;
      tick;
      wb_address = '0; wb_data = '0;
      issue(r_type(5'd1, 5'd5, 5'd0), 32'h100, 32'hDEADBEEF, 32'd0, "add_x5", s);
      check("add_x5_stalls", s, 0);
      wb_address = 5'd1; wb_data = 32'h11;
      tick;
      wb_address = '0;

      // Writes to x0 are ignored; rd=0 never marks busy
      wb_address = '0; wb_data = 32'h12345678;
      issue(r_type(5'd0, 5'd0, 5'd5), 32'h104, 32'd0, 32'hDEADBEEF, "x0_read", s);
      issue(r_type(5'd0, 5'd0, 5'd0), 32'h108, 32'd0, 32'd0, "x0_nobusy", s);
      check("x0_nobusy_stalls", s, 0);
      wb_data = '0;

      // RAW hazard on x3
      issue(i_type(5'd3, 5'd0, 12'd0), 32'h10C, 32'd0, 32'd0, "addi_x3", s);
      raw_release(r_type(5'd4, 5'd3, 5'd0), 32'h110, 5'd3, 32'd7, 32'd7, 32'd0, "raw_x3");
      wb_address = 5'd4; wb_data = 32'h44;
      tick;
      wb_address = '0;

      // Backpressure: bundle held while out_ready is low
      out_ready = 1'b0;
      ir = r_type(5'd0, 5'd5, 5'd0);
      issue(ir, 32'h200, 32'hDEADBEEF, 32'd0, "bp_first", s);
      in_valid = 1'b1; in_PC = 32'h204;
      for (int i = 0; i < 4; i++) begin
         in_IR = r_type(5'd0, 5'd4, 5'(i + 1));
         @(negedge clk);
         check("bp_hold_valid", {31'd0, out_valid}, 32'd1);
         check("bp_hold_IR", out_IR, ir);
         check("bp_hold_A", out_A, 32'hDEADBEEF);
         check("bp_hold_ready", {31'd0, in_ready}, 32'd0);
         tick;
      end
      in_IR = r_type(5'd0, 5'd4, 5'd0);
      out_ready = 1'b1;
      @(negedge clk);
      check("bp_release_ready", {31'd0, in_ready}, 32'd1);
      if (in_ready) push_exp(in_IR, 32'h204, 32'h44, 32'd0);
      tick;
      in_valid = 1'b0;
      @(negedge clk);
      check("bp_next_valid", {31'd0, out_valid}, 32'd1);
      tick;

      // Stores and branches mark nothing busy
      issue(s_type(5'd4, 5'd2, 5'd3), 32'h300, 32'd0, 32'h44, "sw", s);
      issue(b_type(5'd5, 5'd1, 5'd6), 32'h304, 32'hDEADBEEF, 32'h11, "beq", s);
      issue(r_type(5'd0, 5'd3, 5'd6), 32'h308, 32'd7, 32'd0, "after_store", s);
      check("after_store_stalls", s, 0);
      issue(lui(5'd4, 20'd0), 32'h30C, 32'd0, 32'd0, "lui_x4", s);
      raw_release(s_type(5'd4, 5'd0, 5'd0), 32'h310, 5'd4, 32'h99, 32'd0, 32'h99, "raw_x4");

      // Reset while stalled with x3 busy and a bundle in flight
      out_ready = 1'b0;
      issue(i_type(5'd3, 5'd0, 12'd0), 32'h400, 32'd0, 32'd0, "addi_pre_rst", s);
      ir = r_type(5'd0, 5'd3, 5'd0);
      in_valid = 1'b1; in_IR = ir; in_PC = 32'h404;
      @(negedge clk);
      check("pre_rst_stall", {31'd0, in_ready}, 32'd0);
      tick;
      rst = 1'b1;
      exp_q.delete();
      @(negedge clk);
      check("rst_ready_low", {31'd0, in_ready}, 32'd0);
      tick;
      rst = 1'b0; out_ready = 1'b1;
      @(negedge clk);
      check("post_rst_valid", {31'd0, out_valid}, 32'd0);
      check("post_rst_IR", out_IR, 32'd0);
      check("post_rst_no_stall", {31'd0, in_ready}, 32'd1);
      if (in_ready) push_exp(ir, 32'h404, 32'd0, 32'd0);
      tick;
      in_valid = 1'b0;
      @(negedge clk);
      check("post_rst_issue_valid", {31'd0, out_valid}, 32'd1);
      tick;

      repeat (3) tick;
      check("queue_empty", exp_q.size(), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
